// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Classifies debounced key gestures (from key_filter) into one-cycle event
//   pulses: short press, double click, long press and auto-repeat.
// Ports
//   clk, rst_n      : system clock, asynchronous active-low reset
//   en              : 1 = classify, 0 = hold in IDLE with no pulses
//   key_flag        : one-cycle pulse on each debounced edge
//   key_state       : debounced level, 0 = pressed, 1 = released
//   short_pulse     : single click recognised (1 cycle)
//   double_pulse    : double click recognised (1 cycle)
//   long_pulse      : hold reached LONG_MS (1 cycle)
//   repeat_pulse    : periodic pulse while held beyond LONG_MS (1 cycle)
//   busy            : state is not IDLE
module key_event_ctrl #(
    parameter int unsigned TICK_CYC  = 50_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DBL_MS    = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic key_flag,
    input  logic key_state,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned MAX_LD = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
    localparam int unsigned MAX_MS = (MAX_LD > REPEAT_MS) ? MAX_LD : REPEAT_MS;
    localparam int unsigned PW     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned MW     = $clog2(MAX_MS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [MW-1:0]   ms_cnt_q, ms_cnt_d;
    logic            short_q, short_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            busy_q, busy_d;

    logic press;
    logic release_evt;
    logic tick;
    logic reload;

    assign press       = key_flag & ~key_state;
    assign release_evt = key_flag & key_state;
    assign tick        = (prescaler_q == PW'(TICK_CYC - 1));

    // Next state and pulses. Key edges are tested before timer limits so a
    // flag arriving on the limit tick always wins.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        reload   = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (press) state_d = S_PRESS1;
                end
                S_PRESS1: begin
                    if (release_evt) begin
                        state_d = S_WAIT2;
                    end else if (tick && ms_cnt_q == MW'(LONG_MS - 1)) begin
                        state_d = S_LONG;
                        long_d  = 1'b1;
                    end
                end
                S_WAIT2: begin
                    if (press) begin
                        state_d  = S_PRESS2;
                        double_d = 1'b1;
                    end else if (tick && ms_cnt_q == MW'(DBL_MS - 1)) begin
                        state_d = S_IDLE;
                        short_d = 1'b1;
                    end
                end
                S_PRESS2: begin
                    if (release_evt) state_d = S_IDLE;
                end
                S_LONG: begin
                    if (release_evt) begin
                        state_d = S_IDLE;
                    end else if (tick && ms_cnt_q == MW'(REPEAT_MS - 1)) begin
                        repeat_d = 1'b1;
                        reload   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // Timebase restarts on every state change; it is parked at zero in IDLE
    // since nothing there depends on elapsed time.
    always_comb begin
        prescaler_d = '0;
        ms_cnt_d    = '0;
        if (en && state_d == state_q && state_q != S_IDLE) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
            ms_cnt_d    = ms_cnt_q;
            if (tick) begin
                if (reload)
                    ms_cnt_d = '0;
                else if (ms_cnt_q != MW'(MAX_MS))
                    ms_cnt_d = ms_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            ms_cnt_q    <= '0;
            short_q     <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            ms_cnt_q    <= ms_cnt_d;
            short_q     <= short_d;
            double_q    <= double_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            busy_q      <= busy_d;
        end
    end

    assign short_pulse  = short_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl
//   Self-checking bench for key_event_ctrl with small timing parameters.
//   A gesture-level reference model (elapsed-cycle arithmetic per phase)
//   predicts every output each cycle; directed scenarios add absolute
//   timing checks against hand-derived cycle offsets.
module tb_key_event_ctrl;

    localparam int TICK = 50;
    localparam int LMS  = 20;
    localparam int DMS  = 10;
    localparam int RMS  = 5;

    localparam int P_IDLE  = 0;
    localparam int P_HELD1 = 1;
    localparam int P_GAP   = 2;
    localparam int P_HELD2 = 3;
    localparam int P_LONG  = 4;

    logic clk = 1'b0;
    logic rst_n, en, key_flag, key_state;
    logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

    key_event_ctrl #(
        .TICK_CYC (TICK),
        .LONG_MS  (LMS),
        .DBL_MS   (DMS),
        .REPEAT_MS(RMS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    string tag      = "reset";

    // reference model state
    int   m_phase = P_IDLE;
    int   m_n     = 0;
    logic e_short, e_double, e_long, e_repeat, e_busy;

    // observed pulse bookkeeping for directed checks
    int cnt_short, cnt_double, cnt_long, cnt_repeat;
    int last_short, last_double, last_long, last_repeat;

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_n      = 0;
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_repeat = 1'b0;
        e_busy   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        bit pr, rl;
        int el, nxt;
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_repeat = 1'b0;
        if (!rst_n || !en) begin
            m_phase = P_IDLE;
            m_n     = 0;
        end else begin
            pr  = key_flag && !key_state;
            rl  = key_flag && key_state;
            el  = m_n + 1;
            nxt = m_phase;
            case (m_phase)
                P_IDLE:  if (pr) nxt = P_HELD1;
                P_HELD1: begin
                    if (rl) nxt = P_GAP;
                    else if (el == LMS * TICK) begin nxt = P_LONG; e_long = 1'b1; end
                end
                P_GAP: begin
                    if (pr) begin nxt = P_HELD2; e_double = 1'b1; end
                    else if (el == DMS * TICK) begin nxt = P_IDLE; e_short = 1'b1; end
                end
                P_HELD2: if (rl) nxt = P_IDLE;
                P_LONG: begin
                    if (rl) nxt = P_IDLE;
                    else if (el % (RMS * TICK) == 0) e_repeat = 1'b1;
                end
                default: nxt = P_IDLE;
            endcase
            m_n     = (nxt != m_phase) ? 0 : el;
            m_phase = nxt;
        end
        e_busy = (m_phase != P_IDLE);
    endtask

    task automatic check_outputs();
        logic [4:0] obs, exp;
        obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, busy};
        exp = {e_short, e_double, e_long, e_repeat, e_busy};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d outputs{s,d,l,r,busy} observed=%b expected=%b", tag, cyc, obs, exp);
        end
        n_assert++;
        assert ($countones(obs[4:1]) <= 1) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d onehot pulses observed=%b expected<=1 high", tag, cyc, obs[4:1]);
        end
        if (short_pulse)  begin cnt_short++;  last_short  = cyc; end
        if (double_pulse) begin cnt_double++; last_double = cyc; end
        if (long_pulse)   begin cnt_long++;   last_long   = cyc; end
        if (repeat_pulse) begin cnt_repeat++; last_repeat = cyc; end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) cycle();
    endtask

    task automatic flag(input logic lvl);
        key_state = lvl;
        key_flag  = 1'b1;
        cycle();
        key_flag  = 1'b0;
    endtask

    task automatic clr_counts();
        cnt_short = 0; cnt_double = 0; cnt_long = 0; cnt_repeat = 0;
        last_short = -1; last_double = -1; last_long = -1; last_repeat = -1;
    endtask

    task automatic expect_eq(input string name, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    initial begin
        int e0, rel, p2, hold, gap;
        rst_n     = 1'b0;
        en        = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        clr_counts();
        model_reset();
        #2;
        check_outputs();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        // 1: single click
        tag = "s1_short";
        clr_counts();
        flag(1'b0); e0 = cyc;
        wait_cyc(249);
        flag(1'b1); rel = cyc;
        expect_eq("s1_release_edge", rel - e0, 250);
        wait_cyc(520);
        expect_eq("s1_short_cnt", cnt_short, 1);
        expect_eq("s1_short_time", last_short - rel, 500);
        expect_eq("s1_other_cnt", cnt_double + cnt_long + cnt_repeat, 0);

        // 2: double click
        tag = "s2_double";
        clr_counts();
        flag(1'b0);
        wait_cyc(149);
        flag(1'b1);
        wait_cyc(199);
        flag(1'b0); p2 = cyc;
        wait_cyc(50);
        flag(1'b1);
        wait_cyc(600);
        expect_eq("s2_double_cnt", cnt_double, 1);
        expect_eq("s2_double_time", last_double, p2);
        expect_eq("s2_short_cnt", cnt_short, 0);

        // 3: long press with repeats
        tag = "s3_long";
        clr_counts();
        flag(1'b0); e0 = cyc;
        wait_cyc(1849);
        flag(1'b1);
        wait_cyc(600);
        expect_eq("s3_long_cnt", cnt_long, 1);
        expect_eq("s3_long_time", last_long - e0, 1000);
        expect_eq("s3_repeat_cnt", cnt_repeat, 3);
        expect_eq("s3_repeat_last", last_repeat - e0, 1750);
        expect_eq("s3_short_cnt", cnt_short, 0);

        // 4: release exactly on the long-limit edge
        tag = "s4_edge";
        clr_counts();
        flag(1'b0); e0 = cyc;
        wait_cyc(999);
        flag(1'b1); rel = cyc;
        wait_cyc(600);
        expect_eq("s4_long_cnt", cnt_long, 0);
        expect_eq("s4_short_time", last_short - e0, 1500);

        // 5: asynchronous reset mid-gesture
        tag = "s5_reset";
        clr_counts();
        flag(1'b0);
        wait_cyc(100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(40);
        flag(1'b1);
        wait_cyc(600);
        expect_eq("s5_pulse_cnt", cnt_short + cnt_double + cnt_long + cnt_repeat, 0);

        // 6: disabled, then re-enabled single click
        tag = "s6_disabled";
        clr_counts();
        en = 1'b0;
        flag(1'b0); wait_cyc(100);
        flag(1'b1); wait_cyc(100);
        flag(1'b0); wait_cyc(1200);
        flag(1'b1); wait_cyc(600);
        expect_eq("s6_pulse_cnt", cnt_short + cnt_double + cnt_long + cnt_repeat, 0);
        en = 1'b1;
        tag = "s6_reenabled";
        wait_cyc(2);
        flag(1'b0);
        wait_cyc(249);
        flag(1'b1); rel = cyc;
        wait_cyc(520);
        expect_eq("s6_short_time", last_short - rel, 500);

        // randomized gestures with spurious inconsistent flags and en drops
        tag = "random";
        for (int g = 0; g < 30; g++) begin
            en   = ($urandom_range(0, 9) != 0);
            hold = $urandom_range(1, 1400);
            gap  = $urandom_range(1, 700);
            flag(1'b0);
            for (int i = 0; i < hold; i++) begin
                if ($urandom_range(0, 199) == 0) flag(1'b0);
                else cycle();
            end
            flag(1'b1);
            for (int i = 0; i < gap; i++) begin
                if ($urandom_range(0, 199) == 0) flag(1'b1);
                else cycle();
            end
        end
        en = 1'b1;
        wait_cyc(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
